// File: rtl/scan_sequencer_pkg.sv
// Shared constants and state encoding for the scan sequencer slice.
// One source of truth for position count and index width.
package scan_pkg;

  localparam int NUM_POS = 8;
  localparam int POS_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/scan_sequencer_if.sv
// Scan control/observation bundle between a controller (master) and the sequencer (slave).
// num feeds a decoder3_8 stage directly; valid qualifies it.
interface scan_sequencer_if;
  import scan_pkg::*;

  logic               en;
  logic [NUM_POS-1:0] mask;
  logic [POS_W-1:0]   num;
  logic               valid;
  logic               wrap;

  modport master (
    output en,
    output mask,
    input  num,
    input  valid,
    input  wrap
  );

  modport slave (
    input  en,
    input  mask,
    output num,
    output valid,
    output wrap
  );

endinterface

// File: rtl/scan_sequencer_mask_next_pos.sv
// Combinational search: lowest set mask bit strictly above cur, else lowest set bit overall.
// wrapped flags the fallback case; cur=7 turns this into a plain lowest-set-bit finder.
module mask_next_pos
  import scan_pkg::*;
(
  input  logic [NUM_POS-1:0] mask,
  input  logic [POS_W-1:0]   cur,
  output logic [POS_W-1:0]   nxt,
  output logic               wrapped
);

  logic               above_found;
  logic [POS_W-1:0]   above_pos;
  logic [POS_W-1:0]   low_pos;

  // Descending scan so the last hit written is the lowest qualifying index.
  always_comb begin
    above_found = 1'b0;
    above_pos   = '0;
    low_pos     = '0;
    for (int i = NUM_POS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_pos = POS_W'(i);
        if (POS_W'(i) > cur) begin
          above_pos   = POS_W'(i);
          above_found = 1'b1;
        end
      end
    end
    nxt     = above_found ? above_pos : low_pos;
    wrapped = ~above_found;
  end

endmodule

// File: rtl/scan_sequencer.sv
// Steps a 3-bit position index through the enabled mask positions, PERIOD cycles each,
// pulsing wrap when the scan returns to a position at or below the current one.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int PERIOD = 1000,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  scan_sequencer_if.slave  bus
);

  localparam logic [0:0]       S_IDLE = IDLE;
  localparam logic [0:0]       S_RUN  = RUN;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] num_q, num_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  logic [POS_W-1:0] lowest_pos;
  logic             lowest_wrap_unused;
  logic [POS_W-1:0] step_pos;
  logic             step_wrapped;
  logic             go;

  mask_next_pos u_lowest (
    .mask    (bus.mask),
    .cur     (POS_W'(NUM_POS - 1)),
    .nxt     (lowest_pos),
    .wrapped (lowest_wrap_unused)
  );

  mask_next_pos u_step (
    .mask    (bus.mask),
    .cur     (num_q),
    .nxt     (step_pos),
    .wrapped (step_wrapped)
  );

  assign go = bus.en && (bus.mask != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_RUN;
          num_d   = lowest_pos;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        // Leaving RUN wins over a dwell step on the same edge.
        if (!go) begin
          state_d = S_IDLE;
          num_d   = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          cnt_d  = '0;
          num_d  = step_pos;
          wrap_d = step_wrapped;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.num   = num_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: directed scenarios plus randomized en/mask traffic
// compared against a list-based reference model of the scan rules.
module tb_scan_sequencer;
  import scan_pkg::*;

  localparam int PERIOD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_sequencer_if bus ();

  scan_sequencer #(.PERIOD(PERIOD), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: active flag, position, cycles spent at the position so far.
  logic       m_valid;
  logic       m_wrap;
  logic [2:0] m_num;
  int         m_held;

  function automatic int lowest_of(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_wrap = 1'b0; m_num = 3'd0; m_held = 0;
  endtask

  task automatic model_edge();
    int cands[$];
    int nxt;
    if (rst || !bus.en || bus.mask == 8'h00) begin
      model_reset();
    end else if (!m_valid) begin
      m_valid = 1'b1; m_num = 3'(lowest_of(bus.mask)); m_held = 0; m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      m_held++;
      if (m_held == PERIOD) begin
        m_held = 0;
        for (int i = 0; i < 8; i++) if (bus.mask[i]) cands.push_back(i);
        nxt = cands[0];
        foreach (cands[k]) if (cands[k] > int'(m_num)) begin nxt = cands[k]; break; end
        m_wrap = (nxt <= int'(m_num));
        m_num  = 3'(nxt);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic go_idle();
    bus.en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.mask = 8'h00;
    model_reset();
    tick(); tick();
    total++;
    if (bus.num !== 3'd0) begin bad++; $display("FAIL reset_num got=%0d exp=0", bus.num); end
    total++;
    if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    total++;
    if (bus.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_scan();
    logic [2:0] en_num;
    logic       en_wrap;
    go_idle();
    bus.en = 1'b1; bus.mask = 8'hFF;
    tick();
    total++;
    if (bus.valid !== 1'b1 || bus.num !== 3'd0) begin
      bad++; $display("FAIL full_first valid=%b num=%0d exp valid=1 num=0", bus.valid, bus.num);
    end
    for (int c = 1; c <= 70; c++) begin
      tick();
      en_num  = 3'((c / PERIOD) % 8);
      en_wrap = (c % (8 * PERIOD) == 0);
      total++;
      if (bus.num !== en_num || bus.wrap !== en_wrap || bus.valid !== 1'b1) begin
        bad++;
        $display("FAIL full_scan c=%0d got num=%0d wrap=%b valid=%b exp num=%0d wrap=%b valid=1",
                 c, bus.num, bus.wrap, bus.valid, en_num, en_wrap);
      end
    end
  endtask

  task automatic test_sparse();
    int seq [3] = '{2, 5, 7};
    logic [2:0] e_num;
    logic       e_wrap;
    go_idle();
    bus.en = 1'b1; bus.mask = 8'b1010_0100;
    tick();
    for (int c = 1; c <= 40; c++) begin
      tick();
      e_num  = 3'(seq[(c / PERIOD) % 3]);
      e_wrap = (c % (3 * PERIOD) == 0);
      total++;
      if (bus.num !== e_num || bus.wrap !== e_wrap || bus.valid !== 1'b1) begin
        bad++;
        $display("FAIL sparse c=%0d got num=%0d wrap=%b exp num=%0d wrap=%b",
                 c, bus.num, bus.wrap, e_num, e_wrap);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] dec;
    logic       e_wrap;
    go_idle();
    bus.en = 1'b1; bus.mask = 8'h10;
    tick();
    for (int c = 1; c <= 16; c++) begin
      tick();
      dec    = 8'd1 << bus.num;
      e_wrap = (c % PERIOD == 0);
      total++;
      if (dec !== 8'h10 || bus.valid !== 1'b1 || bus.wrap !== e_wrap) begin
        bad++;
        $display("FAIL single c=%0d got dec=%h valid=%b wrap=%b exp dec=10 valid=1 wrap=%b",
                 c, dec, bus.valid, bus.wrap, e_wrap);
      end
    end
  endtask

  task automatic test_en_drop();
    int n;
    go_idle();
    bus.en = 1'b1; bus.mask = 8'hFF;
    n = 0;
    while (n < 100 && !(bus.valid === 1'b1 && bus.num === 3'd3)) begin tick(); n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL en_drop_reach got num=%0d exp=3", bus.num); end
    tick();
    bus.en = 1'b0;
    tick();
    total++;
    if (bus.valid !== 1'b0 || bus.num !== 3'd0 || bus.wrap !== 1'b0) begin
      bad++; $display("FAIL en_drop got valid=%b num=%0d wrap=%b exp 0/0/0", bus.valid, bus.num, bus.wrap);
    end
    bus.en = 1'b1;
    for (int c = 0; c < PERIOD; c++) begin
      tick();
      total++;
      if (bus.valid !== 1'b1 || bus.num !== 3'd0) begin
        bad++; $display("FAIL en_restart c=%0d got valid=%b num=%0d exp 1/0", c, bus.valid, bus.num);
      end
    end
    tick();
    total++;
    if (bus.num !== 3'd1) begin bad++; $display("FAIL en_restart_step got num=%0d exp=1", bus.num); end
  endtask

  task automatic test_mask_edges();
    int n;
    go_idle();
    bus.en = 1'b1; bus.mask = 8'h00;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (bus.valid !== 1'b0) begin bad++; $display("FAIL mask_zero c=%0d got valid=%b exp=0", c, bus.valid); end
    end
    bus.mask = 8'hFF;
    n = 0;
    while (n < 100 && !(bus.valid === 1'b1 && bus.num === 3'd2)) begin tick(); n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL mask_chg_reach got num=%0d exp=2", bus.num); end
    bus.mask = 8'h81;
    for (int c = 1; c < PERIOD; c++) begin
      tick();
      total++;
      if (bus.num !== 3'd2) begin bad++; $display("FAIL mask_chg_hold c=%0d got num=%0d exp=2", c, bus.num); end
    end
    tick();
    total++;
    if (bus.num !== 3'd7 || bus.wrap !== 1'b0) begin
      bad++; $display("FAIL mask_chg_7 got num=%0d wrap=%b exp 7/0", bus.num, bus.wrap);
    end
    repeat (PERIOD) tick();
    total++;
    if (bus.num !== 3'd0 || bus.wrap !== 1'b1) begin
      bad++; $display("FAIL mask_chg_0 got num=%0d wrap=%b exp 0/1", bus.num, bus.wrap);
    end
  endtask

  task automatic test_async_reset();
    int n;
    logic [7:0] m;
    go_idle();
    bus.en = 1'b1; bus.mask = 8'hFF;
    n = 0;
    while (n < 100 && !(bus.valid === 1'b1 && bus.num === 3'd5)) begin tick(); n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL arst_reach got num=%0d exp=5", bus.num); end
    tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    total++;
    if (bus.num !== 3'd0 || bus.valid !== 1'b0 || bus.wrap !== 1'b0) begin
      bad++; $display("FAIL arst_now got num=%0d valid=%b wrap=%b exp 0/0/0", bus.num, bus.valid, bus.wrap);
    end
    tick();
    rst = 1'b0;
    m = 8'($urandom_range(1, 255));
    bus.mask = m;
    tick();
    total++;
    if (bus.valid !== 1'b1 || bus.num !== 3'(lowest_of(m))) begin
      bad++; $display("FAIL arst_release got valid=%b num=%0d exp 1/%0d", bus.valid, bus.num, lowest_of(m));
    end
  endtask

  task automatic test_random();
    go_idle();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 19) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 15) == 0) bus.mask = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      tick();
      total++;
      if ({bus.valid, bus.num, bus.wrap} !== {m_valid, m_num, m_wrap}) begin
        bad++;
        $display("FAIL random c=%0d got v=%b n=%0d w=%b exp v=%b n=%0d w=%b",
                 c, bus.valid, bus.num, bus.wrap, m_valid, m_num, m_wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse();
    test_single();
    test_en_drop();
    test_mask_edges();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Generates the 3-bit position index that drives the decoder3_8 one-hot stage. It steps through the 8 positions of a multiplexed output, such as a display digit scan or a row strobe. It visits only the positions enabled in a mask, holds each one for a fixed dwell period, and pulses a frame marker each time the scan wraps. It sits directly upstream of decoder3_8: its num output connects to the decoder's num input.

Parameters:
PERIOD, 1000, dwell length in clk cycles per position (must be >= 1)
CNT_W, 16, width of the dwell counter (must satisfy 2**CNT_W >= PERIOD)

Ports:
clk  input  1  system clock, all state on its rising edge
rst  input  1  reset; asynchronous and active-high
en  input  1  scan enable; level-sensitive
mask  input  8  position enable; bit i = 1 means position i is visited
num  output  3  current position index, fed to decoder3_8.num
valid  output  1  high while num is a live scan position
wrap  output  1  one-cycle pulse when the scan returns to the lowest enabled position

Behaviour:
- Reset (async assert, released synchronously to clk by the system):
  - num=0, valid=0, wrap=0, dwell counter=0, state=IDLE.
  - Reset asserted mid-scan returns to these values immediately, with no completion of the current dwell.
- All outputs are registered; no combinational path runs from inputs to outputs.
- States:
  - IDLE: valid=0, num=0, wrap=0.
  - RUN: valid=1.
- IDLE -> RUN: en=1 and mask!=0 sampled at edge k.
  - After edge k: num = lowest set bit of mask, valid=1, counter=0.
  - Latency from en to valid is 1 cycle.
- RUN -> IDLE: en=0 or mask==0 sampled at any edge.
  - After that edge: valid=0, num=0, counter=0, wrap=0.
  - This takes priority over a step on the same edge.
- Dwell counter in RUN:
  - Increments every cycle from 0 to PERIOD-1.
  - At PERIOD-1 it wraps to 0, and num loads the next position.
  - Each position is therefore held for exactly PERIOD cycles.
- Next position rule: the lowest set bit of the current mask strictly above num. If none exists, the lowest set bit of mask overall (a wrap).
  - The mask is sampled on the step edge only.
  - Changing the mask mid-dwell does not shorten the dwell, even if the current position is cleared.
- wrap:
  - High for exactly the one cycle following a step edge whose next position is less than or equal to the current num.
  - With a single enabled bit, num is constant and wrap pulses once every PERIOD cycles.
- Entering RUN from IDLE does not pulse wrap.
- PERIOD=1: num changes every cycle; wrap pulses each completed pass.
- Counter arithmetic is unsigned, CNT_W bits; the compare is against PERIOD-1 truncated to CNT_W.

Decomposition:
- Shared package scan_pkg:
  - NUM_POS=8 and POS_W=3 constants.
  - State enum {IDLE, RUN}.
- One combinational sub-module, mask_next_pos:
  - Inputs: mask[7:0], cur[2:0].
  - Outputs: nxt[2:0] and wrapped (1 when the search wrapped to the lowest set bit).
  - The same module also supplies the lowest set bit for IDLE->RUN entry, by passing cur=7 and ignoring wrapped.
- The top holds the FSM, the dwell counter and the output registers.

Test Plan:
- PERIOD=4, mask=8'hFF, en raised at cycle 0 -> valid=1 from cycle 1; num=0,1,...,7, each for 4 cycles; wrap high for 1 cycle when num returns 7->0, repeating every 32 cycles.
- PERIOD=4, mask=8'b1010_0100 -> num sequence 2,5,7,2,5,...; wrap pulses only on each 7->2 step; positions 0,1,3,4,6 never appear.
- PERIOD=4, mask=8'h10 -> num stays 4 continuously; valid=1; wrap pulses once every 4 cycles; decoder3_8 output is steady at 8'h10.
- PERIOD=4, mask=8'hFF, en dropped while num=3 mid-dwell -> on the next cycle valid=0, num=0, wrap=0; re-raising en restarts at num=0 with a full 4-cycle dwell.
- en=1 with mask=0 -> remains IDLE, valid=0. Separately, change mask from 8'hFF to 8'h81 while num=2 -> position 2 completes its dwell, then num=7, then 0 with wrap.
- Assert rst asynchronously mid-dwell (between clk edges) with num=5 -> num=0, valid=0, wrap=0 immediately; after release with en=1, valid=1 one cycle later at the lowest mask bit.
